// File: rtl/traffic_sensor_conditioner_if.sv
// Signal bundle between the raw detector inputs, the conditioner and the traffic light FSM.
interface traffic_sensor_conditioner_if;
  logic v_raw;
  logic z_raw;
  logic v_ack;
  logic V;
  logic Z;
  logic v_db;
  logic z_db;

  modport master (output v_raw, z_raw, v_ack, input V, Z, v_db, z_db);
  modport slave  (input v_raw, z_raw, v_ack, output V, Z, v_db, z_db);
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Synchronize/debounce vehicle and emergency inputs for traffic_light_fsm.
// Optional macro TLC_Z_STRETCH_EN adds a minimum-hold stretch on Z.
module tsc_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        // run of mismatches reached DB_CYCLES: accept the new level
        cnt <= '0;
        db  <= ~db;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module traffic_sensor_conditioner #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  traffic_sensor_conditioner_if.slave   bus
);
  localparam int NUM_CH = 2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  if (DB_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("DB_CYCLES and HOLD_CYCLES must be >= 1");
  end

  logic [NUM_CH-1:0] raw, db;
  logic [0:0]        state;
  logic              v_db_q, v_rise;

  // channel 0 = vehicle, channel 1 = emergency
  assign raw = {bus.z_raw, bus.v_raw};

  tsc_debounce #(.DB_CYCLES(DB_CYCLES)) u_ch [NUM_CH-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw),
    .db    (db)
  );

  assign v_rise = db[0] & ~v_db_q;

  // set beats ack so a fresh request arriving with an ack is not lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      v_db_q <= 1'b0;
    end else begin
      v_db_q <= db[0];
      if (v_rise)         state <= PEND;
      else if (bus.v_ack) state <= IDLE;
    end
  end

  assign bus.V    = (state == PEND);
  assign bus.v_db = db[0];
  assign bus.z_db = db[1];

`ifdef TLC_Z_STRETCH_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [HW-1:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          hold <= '0;
    else if (db[1])      hold <= HW'(HOLD_CYCLES);
    else if (hold != '0) hold <= hold - HW'(1);
  end

  assign bus.Z = db[1] | (hold != '0);
`else
  assign bus.Z = db[1];
`endif
endmodule
